// File: rtl/bp_resolve_queue_pkg.sv
// Shared branch-prediction types used by fetch, the resolve queue and the
// execute branch unit.
//   BP_IDX_W : BHT index width
//   BP_DEPTH : in-flight branch capacity (power of two, >= 2)
//   PTR_W    : queue pointer width
//   bp_entry_t : one in-flight prediction {idx, pred}
package bp_pkg;

  localparam int unsigned BP_IDX_W = 10;
  localparam int unsigned BP_DEPTH = 4;
  localparam int unsigned PTR_W    = $clog2(BP_DEPTH);

  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic                pred;
  } bp_entry_t;

endpackage

// File: rtl/bp_resolve_queue.sv
// In-order queue of in-flight conditional-branch predictions feeding the
// BHT update port. Fetch pushes {idx, pred}; when execute resolves the oldest
// branch the head is popped and a BHT write is issued one cycle later.
// A mispredict discards all younger (wrong-path) entries; flush discards all.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   push, push_idx, push_pred new prediction from fetch
//   full, empty, count       occupancy (derived directly from state)
//   resolve, resolve_taken   oldest branch resolved, actual direction
//   flush                    external pipeline flush
//   bht_load, bht_w_idx,     registered BHT write: strobe, index,
//   bht_taken, bht_correct   predicted direction, prediction correct
//   mispredict               registered; pulses with an incorrect write
module bp_resolve_queue
  import bp_pkg::*;
#(
  // IDX_W must equal BP_IDX_W since storage uses the shared entry type
  parameter int unsigned IDX_W = BP_IDX_W,
  parameter int unsigned DEPTH = BP_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [IDX_W-1:0]           push_idx,
  input  logic                       push_pred,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       resolve,
  input  logic                       resolve_taken,
  input  logic                       flush,
  output logic                       bht_load,
  output logic [IDX_W-1:0]           bht_w_idx,
  output logic                       bht_taken,
  output logic                       bht_correct,
  output logic                       mispredict
);

  localparam int unsigned QPTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH+1);

  bp_entry_t          r_mem [DEPTH];
  logic [QPTR_W-1:0]  r_head;
  logic [QPTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_bht_load;
  logic [IDX_W-1:0]   r_bht_w_idx;
  logic               r_bht_taken;
  logic               r_bht_correct;
  logic               r_mispredict;

  logic [QPTR_W-1:0]  w_head_n;
  logic [QPTR_W-1:0]  w_tail_n;
  logic [CNT_W-1:0]   w_count_n;
  logic               w_bht_load_n;
  logic [IDX_W-1:0]   w_bht_w_idx_n;
  logic               w_bht_taken_n;
  logic               w_bht_correct_n;
  logic               w_mispredict_n;

  bp_entry_t          w_head_e;
  logic               w_resolve_ok;
  logic               w_mispred;
  logic               w_push_ok;
  int                 w_count_calc;

  // Occupancy flags straight from the count register
  assign full        = (r_count == CNT_W'(DEPTH));
  assign empty       = (r_count == '0);
  assign count       = r_count;

  assign bht_load    = r_bht_load;
  assign bht_w_idx   = r_bht_w_idx;
  assign bht_taken   = r_bht_taken;
  assign bht_correct = r_bht_correct;
  assign mispredict  = r_mispredict;

  // Next-state: pointer/count update and the registered BHT write
  always_comb begin
    w_head_n        = r_head;
    w_tail_n        = r_tail;
    w_count_n       = r_count;
    w_bht_load_n    = 1'b0;
    w_bht_w_idx_n   = r_bht_w_idx;
    w_bht_taken_n   = r_bht_taken;
    w_bht_correct_n = r_bht_correct;
    w_mispredict_n  = 1'b0;

    w_head_e     = r_mem[r_head];
    w_resolve_ok = resolve && !empty;
    w_mispred    = w_resolve_ok && (w_head_e.pred != resolve_taken);
    // A full queue still accepts a push when the head leaves the same cycle;
    // pushes alongside a flush or mispredict are wrong-path and dropped.
    w_push_ok    = push && (!full || w_resolve_ok) && !flush && !w_mispred;
    w_count_calc = int'(r_count) + int'(w_push_ok) - int'(w_resolve_ok);

    if (w_resolve_ok) begin
      w_head_n        = r_head + QPTR_W'(1);
      w_bht_load_n    = 1'b1;
      w_bht_w_idx_n   = IDX_W'(w_head_e.idx);
      // BHT expects the predicted direction, not the actual one
      w_bht_taken_n   = w_head_e.pred;
      w_bht_correct_n = (w_head_e.pred == resolve_taken);
      w_mispredict_n  = (w_head_e.pred != resolve_taken);
    end

    // Both discard cases collapse the queue onto the post-resolve head
    if (w_mispred || flush) begin
      w_tail_n  = w_head_n;
      w_count_n = '0;
    end else begin
      if (w_push_ok) begin
        w_tail_n = r_tail + QPTR_W'(1);
      end
      w_count_n = CNT_W'(w_count_calc);
    end
  end

  // State, storage and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_bht_load    <= 1'b0;
      r_bht_w_idx   <= '0;
      r_bht_taken   <= 1'b0;
      r_bht_correct <= 1'b0;
      r_mispredict  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_head        <= w_head_n;
      r_tail        <= w_tail_n;
      r_count       <= w_count_n;
      r_bht_load    <= w_bht_load_n;
      r_bht_w_idx   <= w_bht_w_idx_n;
      r_bht_taken   <= w_bht_taken_n;
      r_bht_correct <= w_bht_correct_n;
      r_mispredict  <= w_mispredict_n;
      if (w_push_ok) begin
        r_mem[r_tail] <= '{idx: BP_IDX_W'(push_idx), pred: push_pred};
      end
    end
  end

  // Occupancy must stay within 0..DEPTH
  a_count_lo: assert property (@(posedge clk) disable iff (!rst_n)
                               w_count_calc >= 0);
  a_count_hi: assert property (@(posedge clk) disable iff (!rst_n)
                               w_count_calc <= int'(DEPTH));

endmodule
